// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared state encoding and big-endian byte-lane helper for imem_loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WRITE  = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // Lane 0 is the most significant byte; also usable on the ROM read side.
    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Streams 32-bit words into byte-wide instruction memory, MSB first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              byte_we,
    output logic [ADDR_W-1:0] byte_addr,
    output logic [7:0]        byte_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [ADDR_W-1:0] count_d;
    logic [1:0]        k, k_d;
    logic [31:0]       word, word_d;
    logic              last, last_d;
    logic [ADDR_W:0]   end_addr;

    // One extra bit so a pointer near 2^ADDR_W can never wrap into range.
    assign end_addr = {1'b0, ptr} + (ADDR_W+1)'(BYTES_PER_WORD - 1);

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        count_d = word_count;
        k_d     = k;
        word_d  = word;
        last_d  = last;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    count_d = '0;
                    if (base_addr[1:0] != 2'b00) begin
                        state_d = ERR;
                    end else begin
                        ptr_d   = base_addr;
                        state_d = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                if (word_valid) begin
                    word_d = word_data;
                    last_d = word_last;
                    if (end_addr > LAST_BYTE) begin
                        state_d = ERR;
                    end else begin
                        k_d     = 2'd0;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (k == 2'd3) begin
                    ptr_d   = ptr + ADDR_W'(BYTES_PER_WORD);
                    count_d = word_count + ADDR_W'(1);
                    state_d = last ? DONE : ACCEPT;
                end else begin
                    k_d = k + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            k          <= 2'd0;
            word       <= '0;
            last       <= 1'b0;
            word_count <= '0;
            word_ready <= 1'b0;
            byte_we    <= 1'b0;
            byte_addr  <= '0;
            byte_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            k          <= k_d;
            word       <= word_d;
            last       <= last_d;
            word_count <= count_d;
            word_ready <= (state_d == ACCEPT);
            byte_we    <= (state_d == WRITE);
            busy       <= (state_d == ACCEPT) || (state_d == WRITE);
            done       <= (state_d == DONE);
            error      <= (state_d == ERR);
            if (state_d == WRITE) begin
                byte_addr <= ptr_d + ADDR_W'(k_d);
                byte_data <= be_byte(word_d, k_d);
            end
        end
    end

    assign cpu_hold = busy;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module : tb_imem_loader
// Brief  : Self-checking bench for imem_loader (vector table, corner sequences, random loads).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        word_last = 1'b0;

    logic        word_ready, byte_we, busy, cpu_hold, done, error;
    logic [31:0] byte_addr, word_count;
    logic [7:0]  byte_data;
    logic        word_ready_8, byte_we_8, busy_8, cpu_hold_8, done_8, error_8;
    logic [31:0] byte_addr_8, word_count_8;
    logic [7:0]  byte_data_8;

    imem_loader #(.ADDR_W(32), .MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(word_ready), .byte_we(byte_we), .byte_addr(byte_addr),
        .byte_data(byte_data), .busy(busy), .cpu_hold(cpu_hold), .done(done),
        .error(error), .word_count(word_count)
    );

    imem_loader #(.ADDR_W(32), .MEM_BYTES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(word_ready_8), .byte_we(byte_we_8), .byte_addr(byte_addr_8),
        .byte_data(byte_data_8), .busy(busy_8), .cpu_hold(cpu_hold_8), .done(done_8),
        .error(error_8), .word_count(word_count_8)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t wq[$];
    wr_t wq8[$];
    wr_t expq[$];
    wr_t mon_e, mon_e8;

    always @(negedge clk) begin
        if (byte_we === 1'b1) begin
            mon_e.a = byte_addr;
            mon_e.d = byte_data;
            wq.push_back(mon_e);
        end
        if (byte_we_8 === 1'b1) begin
            mon_e8.a = byte_addr_8;
            mon_e8.d = byte_data_8;
            wq8.push_back(mon_e8);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        wq.delete();
        wq8.delete();
    endtask

    // Expected memory image of one word: big-endian, MSB at the lowest address.
    task automatic exp_word(input logic [31:0] addr, input logic [31:0] w);
        wr_t e;
        for (int j = 0; j < 4; j++) begin
            e.a = 32'(addr + 32'(j));
            e.d = 8'(w >> (24 - 8 * j));
            expq.push_back(e);
        end
    endtask

    task automatic cmp_writes(input string name, input bit use8);
        wr_t act[$];
        if (use8) act = wq8;
        else      act = wq;
        check($sformatf("%s_nwrites", name), act.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < act.size())
                check($sformatf("%s_wr%0d", name, i), {act[i].a, act[i].d}, {expq[i].a, expq[i].d});
        end
    endtask

    task automatic wait_ready(input bit use8);
        for (int i = 0; i < 50; i++) begin
            if ((use8 ? word_ready_8 : word_ready) === 1'b1) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout: got word_ready=0 expected 1 within 50 cycles");
    endtask

    task automatic send_word(input logic [31:0] w, input bit last, input bit use8);
        word_valid = 1'b1;
        word_data  = w;
        word_last  = last;
        wait_ready(use8);
        step();
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (busy === 1'b0) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: got busy=1 expected 0 within 50 cycles");
    endtask

    typedef struct {
        bit          st;
        logic [31:0] base;
        bit          v;
        logic [31:0] d;
        bit          l;
        bit          rdy;
        bit          we;
        logic [31:0] a;
        logic [7:0]  bd;
        bit          bsy;
        bit          dn;
        bit          er;
        logic [31:0] cnt;
    } vec_t;

    vec_t tv[9];

    logic [31:0] w3[3];
    int          rc[$];
    int          idx;
    bit          hs;
    logic [31:0] rw[6];
    logic [31:0] rbase, addr;
    int          n, n_send, exp_cnt;
    bit          exp_err;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        //            st base v  data          l  rdy we a  bd     bsy dn er cnt
        tv[0] = '{1, 0, 0, 0,            0, 1, 0, 0, 8'h00, 1, 0, 0, 0};
        tv[1] = '{0, 0, 1, 32'h8C02000E, 1, 0, 1, 0, 8'h8C, 1, 0, 0, 0};
        tv[2] = '{0, 0, 0, 0,            0, 0, 1, 1, 8'h02, 1, 0, 0, 0};
        tv[3] = '{0, 0, 0, 0,            0, 0, 1, 2, 8'h00, 1, 0, 0, 0};
        tv[4] = '{0, 0, 0, 0,            0, 0, 1, 3, 8'h0E, 1, 0, 0, 0};
        tv[5] = '{0, 0, 0, 0,            0, 0, 0, 3, 8'h0E, 0, 1, 0, 1};
        tv[6] = '{0, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 3, 8'h0E, 0, 1, 0, 1};
        tv[7] = '{1, 2, 0, 0,            0, 0, 0, 3, 8'h0E, 0, 0, 1, 0};
        tv[8] = '{1, 0, 0, 0,            0, 1, 0, 3, 8'h0E, 1, 0, 0, 0};

        // Reset values, sampled while reset is held.
        rst_n = 1'b0;
        #13;
        check("rst_ready", word_ready, 0);
        check("rst_we",    byte_we,    0);
        check("rst_busy",  busy,       0);
        check("rst_hold",  cpu_hold,   0);
        check("rst_done",  done,       0);
        check("rst_error", error,      0);
        check("rst_count", word_count, 0);
        check("rst_addr",  byte_addr,  0);
        check("rst_data",  byte_data,  0);
        do_reset();

        // Single word, misaligned start, and restart from ERR.
        for (int i = 0; i < 9; i++) begin
            start      = tv[i].st;
            base_addr  = tv[i].base;
            word_valid = tv[i].v;
            word_data  = tv[i].d;
            word_last  = tv[i].l;
            step();
            check($sformatf("v%0d_ready", i), word_ready, tv[i].rdy);
            check($sformatf("v%0d_we",    i), byte_we,    tv[i].we);
            check($sformatf("v%0d_addr",  i), byte_addr,  tv[i].a);
            check($sformatf("v%0d_data",  i), byte_data,  tv[i].bd);
            check($sformatf("v%0d_busy",  i), busy,       tv[i].bsy);
            check($sformatf("v%0d_hold",  i), cpu_hold,   tv[i].bsy);
            check($sformatf("v%0d_done",  i), done,       tv[i].dn);
            check($sformatf("v%0d_error", i), error,      tv[i].er);
            check($sformatf("v%0d_count", i), word_count, tv[i].cnt);
        end
        start = 1'b0;
        word_valid = 1'b0;
        check("table_total_writes", wq.size(), 4);

        // Three-word image, valid held high throughout.
        do_reset();
        w3[0] = 32'h41290002;
        w3[1] = 32'h00000000;
        w3[2] = 32'h00623020;
        expq.delete();
        for (int i = 0; i < 3; i++) exp_word(32'(4 + 4 * i), w3[i]);
        rc.delete();
        start = 1'b1;
        base_addr = 32'd4;
        step();
        start = 1'b0;
        word_valid = 1'b1;
        word_data = w3[0];
        word_last = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (done === 1'b1) break;
            check($sformatf("img3_hold_c%0d", cyc), cpu_hold, 1);
            hs = (word_ready === 1'b1);
            if (hs) rc.push_back(cyc);
            step();
            if (hs && idx < 3) begin
                idx++;
                if (idx == 3) begin
                    word_valid = 1'b0;
                    word_last = 1'b0;
                end else begin
                    word_data = w3[idx];
                    word_last = (idx == 2);
                end
            end
        end
        check("img3_done",  done,       1);
        check("img3_busy",  busy,       0);
        check("img3_count", word_count, 3);
        check("img3_nready", rc.size(), 3);
        if (rc.size() >= 3) begin
            check("img3_gap1", rc[1] - rc[0], 5);
            check("img3_gap2", rc[2] - rc[1], 5);
        end
        cmp_writes("img3", 0);

        // MEM_BYTES=8: second word would cross the end of memory.
        do_reset();
        expq.delete();
        exp_word(32'd4, 32'hA1B2C3D4);
        start = 1'b1;
        base_addr = 32'd4;
        step();
        start = 1'b0;
        send_word(32'hA1B2C3D4, 1'b0, 1'b1);
        send_word(32'h55667788, 1'b1, 1'b1);
        check("m8_error", error_8, 1);
        check("m8_done",  done_8,  0);
        check("m8_busy",  busy_8,  0);
        check("m8_count", word_count_8, 1);
        repeat (3) step();
        cmp_writes("m8", 1);

        // Asynchronous reset in the middle of a word.
        do_reset();
        start = 1'b1;
        base_addr = 32'd0;
        step();
        start = 1'b0;
        send_word(32'hDEADBEEF, 1'b1, 1'b0);
        step();
        check("rw_we_before", byte_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_we",    byte_we,    0);
        check("rw_ready", word_ready, 0);
        check("rw_busy",  busy,       0);
        check("rw_hold",  cpu_hold,   0);
        check("rw_done",  done,       0);
        check("rw_count", word_count, 0);
        check("rw_addr",  byte_addr,  0);
        check("rw_data",  byte_data,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("rw_post_ready", word_ready, 0);
        check("rw_post_busy",  busy,       0);
        check("rw_post_we",    byte_we,    0);
        check("rw_post_error", error,      0);

        // start pulsed mid-word must be ignored.
        do_reset();
        expq.delete();
        exp_word(32'd16, 32'h01020304);
        exp_word(32'd20, 32'h0A0B0C0D);
        start = 1'b1;
        base_addr = 32'd16;
        step();
        start = 1'b0;
        send_word(32'h01020304, 1'b0, 1'b0);
        start = 1'b1;
        base_addr = 32'h100;
        step();
        start = 1'b0;
        send_word(32'h0A0B0C0D, 1'b1, 1'b0);
        wait_idle();
        check("sw_done",  done,       1);
        check("sw_count", word_count, 2);
        cmp_writes("sw", 0);

        // Random loads against a list-of-writes model.
        do_reset();
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < 6; i++) rw[i] = $urandom;
            case ($urandom_range(0, 9))
                0, 1:    rbase = 32'($urandom_range(0, 200) * 4 + $urandom_range(1, 3));
                2, 3:    rbase = 32'(1024 - 4 * $urandom_range(1, 4));
                4:       rbase = 32'hFFFFFFF8;
                default: rbase = 32'($urandom_range(0, 200) * 4);
            endcase
            expq.delete();
            wq.delete();
            exp_err = 1'b0;
            exp_cnt = 0;
            n_send  = n;
            if (rbase[1:0] != 2'b00) begin
                exp_err = 1'b1;
                n_send  = 0;
            end else begin
                for (int i = 0; i < n; i++) begin
                    addr = rbase + 32'(4 * i);
                    if (longint'(addr) + 3 > 1023) begin
                        exp_err = 1'b1;
                        n_send  = i + 1;
                        break;
                    end
                    exp_word(addr, rw[i]);
                    exp_cnt++;
                end
            end
            start = 1'b1;
            base_addr = rbase;
            step();
            start = 1'b0;
            for (int i = 0; i < n_send; i++) begin
                repeat ($urandom_range(0, 3)) step();
                send_word(rw[i], (i == n - 1), 1'b0);
            end
            wait_idle();
            check($sformatf("rnd%0d_error", t), error, exp_err);
            check($sformatf("rnd%0d_done",  t), done,  !exp_err);
            check($sformatf("rnd%0d_count", t), word_count, exp_cnt);
            cmp_writes($sformatf("rnd%0d", t), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart of the byte-addressed instruction ROM. It accepts 32-bit instruction words over a valid/ready stream and writes each word into byte-wide instruction memory as four big-endian bytes: MSB at addr, LSB at addr+3.
- Sits between the boot/test-load path and the instruction memory write port.
- Holds the pipeline (cpu_hold) while a program image is being loaded.

Parameters:
- ADDR_W, 32, width of byte address and base address.
- MEM_BYTES, 1024, size of target memory in bytes; a write beyond MEM_BYTES-1 is an error.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin a load at base_addr.
- base_addr  in  ADDR_W  byte address of the first word; must be 4-byte aligned.
- word_valid  in  1  producer has a word on word_data.
- word_data  in  32  instruction word.
- word_last  in  1  qualifies the final word of the image; sampled with word_data.
- word_ready  out  1  loader can accept a word this cycle.
- byte_we  out  1  byte write strobe to instruction memory.
- byte_addr  out  ADDR_W  byte write address.
- byte_data  out  8  byte write data.
- busy  out  1  load in progress.
- cpu_hold  out  1  pipeline stall request; equal to busy.
- done  out  1  image loaded; held until next start.
- error  out  1  misaligned base or overflow; held until next start.
- word_count  out  ADDR_W  number of words fully written in the current load.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal pointer, byte index and word_count cleared. Any write in flight is abandoned immediately with byte_we=0. There is no partial-word completion after reset.
- States: IDLE, ACCEPT, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start=1:
  - Clear done, error and word_count.
  - If base_addr[1:0]!=0, go to ERR (error=1, no writes).
  - Otherwise ptr<=base_addr and go to ACCEPT.
- start while in ACCEPT or WRITE is ignored.
- ACCEPT: word_ready=1.
  - On word_valid&&word_ready, capture word_data/word_last.
  - If ptr+3 > MEM_BYTES-1, go to ERR and write no bytes of that word.
  - Otherwise go to WRITE with byte index k=0.
- WRITE: byte_we=1, byte_addr=ptr+k, byte_data=word[31-8k -: 8], for k=0..3 on consecutive cycles. word_ready=0.
- After k=3:
  - ptr<=ptr+4 and word_count<=word_count+1.
  - If captured last=1, go to DONE; else go to ACCEPT.
- Timing: handshake at edge N. Bytes 0..3 are presented in cycles N+1..N+4. word_ready is asserted again in cycle N+5. Sustained throughput is one word per 5 cycles.
- busy=cpu_hold=1 in ACCEPT and WRITE, 0 otherwise. done=1 only in DONE. error=1 only in ERR.
- Outputs are registered (Moore). byte_addr/byte_data hold their last values when byte_we=0.
- A word with word_last=1 completes all four bytes before done rises.
- word_valid is ignored outside ACCEPT.
- Address arithmetic is modulo 2^ADDR_W internally. The overflow check uses ADDR_W+1 bits so wrap-around is never treated as in-range.

Decomposition:
- Shared package:
  - state enum (IDLE, ACCEPT, WRITE, DONE, ERR);
  - BYTES_PER_WORD=4;
  - big-endian byte-lane select function (word, k) -> byte.
- No sub-module needed; one FSM with a 2-bit byte counter and an address register. The byte-lane select can also serve the existing ROM read path.

Test Plan:
- Reset then start with base_addr=0 and one word 0x8C02000E, last=1 -> byte writes 0x8C@0, 0x02@1, 0x00@2, 0x0E@3 in four consecutive cycles; done=1; word_count=1; busy low afterwards.
- Three-word image (0x41290002, 0x00000000, 0x00623020 last) at base 4 with word_valid held high -> 12 writes at addresses 4..15; word_ready high every 5th cycle; word_count=3; cpu_hold high throughout.
- start with base_addr=2 -> error=1 next cycle; no byte_we pulses; a new start at base 0 clears error.
- MEM_BYTES=8, base 4, two words -> first word written at 4..7; second handshake sends FSM to ERR with zero writes; word_count=1.
- rst_n low during cycle N+2 of a WRITE -> byte_we drops immediately; all outputs 0; after release, state IDLE and word_ready=0.
- start pulsed during WRITE -> ignored; ptr and word_count unaffected; load finishes normally.
